// File: rtl/input_debouncer.sv
// input_debouncer: two-flop synchroniser followed by a STABLE/PENDING debounce
// FSM. Produces a clean registered level, one-cycle edge strobes, a wrapping
// accepted-edge counter and a saturating rejected-transition counter.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       din,
    output logic       dout,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic [7:0] edge_count,
    output logic [3:0] glitch_count
);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    // Last count value of a pending transition; reaching it with the new
    // level still present accepts the transition on that edge.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam int SYNC_STAGES = 2;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   s2;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             dout_reg, dout_next;
    logic             rise_reg, rise_next;
    logic             fall_reg, fall_next;
    logic [7:0]       edge_reg, edge_next;
    logic [3:0]       glitch_reg, glitch_next;

    // Synchroniser chain: stage 0 samples the pin, each later stage samples
    // the one before it. Runs regardless of ena.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = din;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign s2 = sync_reg[SYNC_STAGES-1];

    // Synchroniser registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= sync_next;
        end
    end

    // FSM state, debounce counter, level, strobes and statistics registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_STABLE;
            cnt_reg    <= '0;
            dout_reg   <= 1'b0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
            edge_reg   <= '0;
            glitch_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            dout_reg   <= dout_next;
            rise_reg   <= rise_next;
            fall_reg   <= fall_next;
            edge_reg   <= edge_next;
            glitch_reg <= glitch_next;
        end
    end

    // Next-state logic: hold everything (strobes low) unless enabled, then
    // track how long s2 has disagreed with the accepted level.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        dout_next   = dout_reg;
        rise_next   = 1'b0;
        fall_next   = 1'b0;
        edge_next   = edge_reg;
        glitch_next = glitch_reg;

        if (ena) begin
            case (state_reg)
                ST_STABLE: begin
                    if (s2 != dout_reg) begin
                        state_next = ST_PENDING;
                        cnt_next   = CNT_W'(1);
                    end
                end
                ST_PENDING: begin
                    if (s2 == dout_reg) begin
                        // New level vanished before the window closed.
                        state_next = ST_STABLE;
                        cnt_next   = '0;
                        if (glitch_reg != 4'hF) begin
                            glitch_next = glitch_reg + 4'd1;
                        end
                    end else if (cnt_reg == CNT_LAST) begin
                        state_next = ST_STABLE;
                        cnt_next   = '0;
                        dout_next  = ~dout_reg;
                        rise_next  = ~dout_reg;
                        fall_next  = dout_reg;
                        edge_next  = edge_reg + 8'd1;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = ST_STABLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign dout         = dout_reg;
    assign rise_pulse   = rise_reg;
    assign fall_pulse   = fall_reg;
    assign edge_count   = edge_reg;
    assign glitch_count = glitch_reg;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed scenarios plus a randomized phase, all
// checked every cycle against a run-length reference model of the debouncer.
module tb_input_debouncer;

    localparam int D = 16;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       din;
    logic       dout;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] edge_count;
    logic [3:0] glitch_count;

    int errors = 0;
    int checks = 0;
    int n_rise = 0;
    int n_fall = 0;

    // Reference model state
    logic m_s1, m_s2, m_dout, m_rise, m_fall;
    int   m_run, m_edges, m_glitch;

    input_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .din          (din),
        .dout         (dout),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .edge_count   (edge_count),
        .glitch_count (glitch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model: the level flips once s2 has differed from it on D consecutive
    // enabled edges; a shorter disagreement counts as one glitch.
    task automatic model_update();
        logic old_s1;
        old_s1 = m_s1;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_dout = 0;
            m_run = 0; m_edges = 0; m_glitch = 0;
        end else begin
            if (ena) begin
                if (m_s2 != m_dout) begin
                    m_run++;
                    if (m_run == D) begin
                        m_dout  = ~m_dout;
                        m_rise  = m_dout;
                        m_fall  = ~m_dout;
                        m_edges = (m_edges + 1) % 256;
                        m_run   = 0;
                    end
                end else begin
                    if (m_run > 0 && m_glitch < 15) m_glitch++;
                    m_run = 0;
                end
            end
            m_s1 = din;
            m_s2 = old_s1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("dout", 32'(dout), 32'(m_dout));
        chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
        chk("fall_pulse", 32'(fall_pulse), 32'(m_fall));
        chk("edge_count", 32'(edge_count), 32'(m_edges));
        chk("glitch_count", 32'(glitch_count), 32'(m_glitch));
        chk("pulse_exclusive", 32'(rise_pulse & fall_pulse), 32'd0);
        if (rise_pulse === 1'b1) n_rise++;
        if (fall_pulse === 1'b1) n_fall++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until a pulse appears; returns the number of steps taken
    // (the first step is edge E0), bounded to avoid hanging.
    task automatic wait_pulse(output int lat);
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            lat++;
            if (rise_pulse === 1'b1 || fall_pulse === 1'b1) break;
        end
    endtask

    task automatic do_reset(input logic d);
        din   = d;
        ena   = 1'b1;
        rst_n = 1'b0;
        steps(3);
        rst_n = 1'b1;
        steps(4);
        n_rise = 0;
        n_fall = 0;
    endtask

    initial begin
        int lat;
        int rise_before;
        logic rd;

        clk = 0; rst_n = 0; ena = 1; din = 1;
        m_s1 = 0; m_s2 = 0; m_dout = 0; m_rise = 0; m_fall = 0;
        m_run = 0; m_edges = 0; m_glitch = 0;

        // Reset with din high: outputs 0, then a single rise 17 edges later
        steps(3);
        chk("reset_dout", 32'(dout), 32'd0);
        chk("reset_edge_count", 32'(edge_count), 32'd0);
        rst_n = 1;
        n_rise = 0;
        wait_pulse(lat);
        chk("reset_release_latency", 32'(lat - 1), 32'(D + 1));
        steps(5);
        chk("reset_release_rises", 32'(n_rise), 32'd1);
        chk("reset_release_edges", 32'(edge_count), 32'd1);

        // Clean toggle
        do_reset(1'b0);
        din = 1;
        wait_pulse(lat);
        chk("rise_latency", 32'(lat - 1), 32'(D + 1));
        steps(30);
        din = 0;
        wait_pulse(lat);
        chk("fall_latency", 32'(lat - 1), 32'(D + 1));
        steps(30);
        chk("toggle_edges", 32'(edge_count), 32'd2);
        chk("toggle_glitches", 32'(glitch_count), 32'd0);
        chk("toggle_rises", 32'(n_rise), 32'd1);
        chk("toggle_falls", 32'(n_fall), 32'd1);

        // Bounce: 20 short high bursts, then a long hold
        do_reset(1'b0);
        for (int k = 0; k < 20; k++) begin
            din = 1; steps(5);
            din = 0; steps(3);
        end
        chk("bounce_rises", 32'(n_rise), 32'd0);
        chk("bounce_dout", 32'(dout), 32'd0);
        chk("bounce_glitch_sat", 32'(glitch_count), 32'd15);
        din = 1;
        steps(30);
        chk("bounce_final_rises", 32'(n_rise), 32'd1);
        chk("bounce_final_edges", 32'(edge_count), 32'd1);

        // Boundary: 15-cycle run rejected, 16-cycle run accepted
        do_reset(1'b0);
        din = 1; steps(D - 1);
        din = 0; steps(10);
        chk("boundary_short_glitch", 32'(glitch_count), 32'd1);
        chk("boundary_short_dout", 32'(dout), 32'd0);
        din = 1; steps(D);
        din = 0; steps(2);
        chk("boundary_exact_dout", 32'(dout), 32'd1);
        steps(40);
        chk("boundary_exact_rises", 32'(n_rise), 32'd1);
        chk("boundary_exact_glitch", 32'(glitch_count), 32'd1);

        // Enable freeze for 10 cycles in the middle of a pending rise
        do_reset(1'b0);
        din = 1;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            if (i == 8) ena = 0;
            if (i == 18) ena = 1;
            step();
            lat++;
            if (rise_pulse === 1'b1) break;
        end
        chk("freeze_latency", 32'(lat - 1), 32'(D + 1 + 10));
        chk("freeze_rises", 32'(n_rise), 32'd1);

        // Randomized: random run lengths, random enable drops, rare resets
        do_reset(1'b0);
        for (int r = 0; r < 120; r++) begin
            int len;
            din = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 24);
            for (int j = 0; j < len; j++) begin
                ena   = ($urandom_range(0, 7) != 0);
                rst_n = ($urandom_range(0, 199) != 0);
                step();
            end
        end
        rst_n = 1; ena = 1;

        // Wrap: 256 clean edges bring edge_count back to 0
        do_reset(1'b0);
        rd = 0;
        for (int k = 0; k < 256; k++) begin
            rd  = ~rd;
            din = rd;
            steps(D + 2);
        end
        chk("wrap_edges", 32'(edge_count), 32'd0);
        chk("wrap_rises", 32'(n_rise), 32'd128);
        chk("wrap_falls", 32'(n_fall), 32'd128);

        // Reset during a pending transition
        din = 1;
        steps(6);
        rise_before = n_rise;
        rst_n = 0;
        steps(2);
        chk("midreset_rises", 32'(n_rise), 32'(rise_before));
        chk("midreset_dout", 32'(dout), 32'd0);
        chk("midreset_edges", 32'(edge_count), 32'd0);
        chk("midreset_glitch", 32'(glitch_count), 32'd0);
        rst_n = 1;
        steps(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
